// File: rtl/wb_queue.sv
// Writeback queue: merges MEM and ALU results into one register-file write port.
// Define WBQ_FWD_EN to add youngest-match forwarding outputs for SR1/SR2.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  HLT,
    input  logic                  MemValid,
    output logic                  MemReady,
    input  logic [4:0]            MemDR,
    input  logic [31:0]           MemData,
    input  logic                  AluValid,
    output logic                  AluReady,
    input  logic [4:0]            AluDR,
    input  logic [31:0]           AluData,
    output logic                  RegW,
    output logic [4:0]            DR,
    output logic [31:0]           Reg_In,
    input  logic [4:0]            SR1,
    input  logic [4:0]            SR2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic [$clog2(DEPTH):0] Count,
    output logic                  Full,
    output logic                  Empty
`ifdef WBQ_FWD_EN
    ,
    output logic                  Fwd1Valid,
    output logic [31:0]           Fwd1Data,
    output logic                  Fwd2Valid,
    output logic [31:0]           Fwd2Data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_M1  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_M2  = CW'(DEPTH - 2);

    logic [4:0]    ent_dr_q   [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wa_alu;
    logic [CW-1:0] count_q, count_d;
    logic          regw_q;
    logic [4:0]    out_dr_q;
    logic [31:0]   out_data_q;

    logic pop, mem_push, alu_push;
    logic busy1, busy2;

    // Readiness looks only at the registered count; a same-cycle pop gives no credit.
    assign MemReady = (count_q < CNT_MAX);
    assign AluReady = (count_q <= CNT_M2) || ((count_q == CNT_M1) && !MemValid);

    always_comb begin
        pop      = !HLT && (count_q != '0);
        mem_push = MemValid && MemReady && (MemDR != 5'd0);
        alu_push = AluValid && AluReady && (AluDR != 5'd0);
        wa_alu   = wr_ptr_q + PW'(mem_push);
        wr_ptr_d = wa_alu + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            regw_q     <= 1'b0;
            out_dr_q   <= 5'd0;
            out_data_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_dr_q[i]   <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            regw_q   <= pop;
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                out_dr_q        <= ent_dr_q[rd_ptr_q];
                out_data_q      <= ent_data_q[rd_ptr_q];
            end
            if (mem_push) begin
                vld_q[wr_ptr_q]      <= 1'b1;
                ent_dr_q[wr_ptr_q]   <= MemDR;
                ent_data_q[wr_ptr_q] <= MemData;
            end
            if (alu_push) begin
                vld_q[wa_alu]      <= 1'b1;
                ent_dr_q[wa_alu]   <= AluDR;
                ent_data_q[wa_alu] <= AluData;
            end
        end
    end

    always_comb begin
        busy1 = regw_q && (out_dr_q == SR1);
        busy2 = regw_q && (out_dr_q == SR2);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_dr_q[i] == SR1)) busy1 = 1'b1;
            if (vld_q[i] && (ent_dr_q[i] == SR2)) busy2 = 1'b1;
        end
    end

    assign Busy1  = busy1 && (SR1 != 5'd0);
    assign Busy2  = busy2 && (SR2 != 5'd0);
    assign RegW   = regw_q;
    assign DR     = out_dr_q;
    assign Reg_In = out_data_q;
    assign Count  = count_q;
    assign Full   = (count_q == CNT_MAX);
    assign Empty  = (count_q == '0);

`ifdef WBQ_FWD_EN
    logic [31:0]   f1d, f2d;
    logic [PW-1:0] idx;

    // Walk from head to tail so the youngest match wins; output register is oldest.
    always_comb begin
        f1d = out_data_q;
        f2d = out_data_q;
        idx = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (vld_q[idx] && (ent_dr_q[idx] == SR1)) f1d = ent_data_q[idx];
            if (vld_q[idx] && (ent_dr_q[idx] == SR2)) f2d = ent_data_q[idx];
        end
    end

    assign Fwd1Valid = Busy1;
    assign Fwd2Valid = Busy2;
    assign Fwd1Data  = Busy1 ? f1d : 32'd0;
    assign Fwd2Data  = Busy2 ? f2d : 32'd0;
`endif

endmodule
